// File: rtl/serial_adder_pkg.sv
// serial_pkg: shared definitions for the bit-serial adder slice.
//   - state_t     : FSM state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/sum width
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result buses.
//
// Handshake: start is sampled on a rising clk edge only while busy=0. The
// operands a/b/cin are captured on that same edge, and may change freely
// afterwards. busy stays high while the addition runs. done pulses for
// exactly one cycle when sum/cout take on the new result. sum/cout then
// hold that value until the next completion.
//
//   master : requester (drives start, a, b, cin)
//   slave  : adder     (drives busy, done, sum, cout)
interface serial_adder_if #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: one-bit full-adder cell.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. One bit per clock, LSB first,
// goes through a single fa_bit cell. The carry is kept in a flop between bits.
// The result {cout,sum} = a + b + cin is ready WIDTH clocks after start is accepted.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of serial_adder_if (start/a/b/cin in,
//                busy/done/sum/cout out, all outputs registered)
//   state      : current FSM state, for observation
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus,
    output state_t        state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit, c_bit;
    logic             load, finish;

    fa_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // start is accepted in IDLE and also in the DONE cycle, which gives
    // back-to-back operation.
    assign load   = (state_q != RUN) && bus.start;
    assign finish = (state_q == RUN) && (cnt == LAST);
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt == LAST) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else if (load) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            carry    <= bus.cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
        end else if (state_q == RUN) begin
            s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= c_bit;
            if (finish) begin
                // Reset cnt here rather than incrementing it, so it can
                // never wrap when WIDTH is a power of two.
                cnt      <= '0;
                bus.sum  <= {s_bit, s_sr[WIDTH-1:1]};
                bus.cout <= c_bit;
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            bus.done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    import serial_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state;

    int n_vec = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];

    serial_adder_if #(.WIDTH(W)) bus_if ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .state (state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one addition. If poke is set, a second start with 0x01+0x01 is
    // pulsed at cycle 3 of RUN, and it must be ignored. Operands are scrambled
    // after capture.
    task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] exp_sum,
                           input logic exp_cout, input bit poke);
        int cycles;
        int busy_cnt;
        logic [W:0] exp;
        exp_q.push_back({exp_cout, exp_sum});
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.cin   = cin;
        tick();  // start-sampling edge
        cycles   = 0;
        busy_cnt = 0;
        while (!bus_if.done && cycles < 50) begin
            if (bus_if.busy) busy_cnt++;
            if (poke && cycles == 3) begin
                bus_if.start = 1'b1;
                bus_if.a     = 8'h01;
                bus_if.b     = 8'h01;
            end else begin
                bus_if.start = 1'b0;
                bus_if.a     = W'($urandom);
                bus_if.b     = W'($urandom);
                bus_if.cin   = 1'($urandom);
            end
            tick();
            cycles++;
        end
        bus_if.start = 1'b0;
        check({tag, " latency"}, cycles, W);
        check({tag, " busy cycles"}, busy_cnt, W);
        exp = exp_q.pop_front();
        check({tag, " sum"}, bus_if.sum, exp[W-1:0]);
        check({tag, " cout"}, bus_if.cout, exp[W]);
        tick();
        check({tag, " done pulse width"}, bus_if.done, 0);
        check({tag, " idle busy"}, bus_if.busy, 0);
    endtask

    initial begin : main
        int   cycles;
        bit   saw_done;
        int   bad_hold;

        // reset with random inputs
        bus_if.start = 1'($urandom);
        bus_if.a     = W'($urandom);
        bus_if.b     = W'($urandom);
        bus_if.cin   = 1'($urandom);
        rst_n        = 1'b0;
        tick();
        tick();
        check("reset busy", bus_if.busy, 0);
        check("reset done", bus_if.done, 0);
        check("reset sum", bus_if.sum, 0);
        check("reset cout", bus_if.cout, 0);
        check("reset state", state, IDLE);
        bus_if.start = 1'b0;
        rst_n        = 1'b1;
        saw_done     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_if.busy || bus_if.done) saw_done = 1'b1;
        end
        check("post-reset quiet", saw_done, 0);

        // basic and carry-ripple vectors
        run_add("basic 5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
        run_add("ripple ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("ripple ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // ignored start while busy, scrambled operands, hold
        run_add("busy start 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            bus_if.a = W'($urandom);
            bus_if.b = W'($urandom);
            tick();
            if (bus_if.sum !== 8'h30 || bus_if.done !== 1'b0) bad_hold++;
        end
        check("hold 20 cycles", bad_hold, 0);

        // back-to-back with start held high
        bus_if.start = 1'b1;
        bus_if.a     = 8'h01;
        bus_if.b     = 8'h02;
        bus_if.cin   = 1'b0;
        tick();
        bus_if.a = 8'h7F;
        bus_if.b = 8'h01;
        cycles   = 0;
        while (!bus_if.done && cycles < 50) begin
            tick();
            cycles++;
        end
        check("b2b first latency", cycles, W);
        check("b2b first sum", bus_if.sum, 8'h03);
        check("b2b first cout", bus_if.cout, 0);
        cycles = 0;
        tick();
        cycles++;
        while (!bus_if.done && cycles < 50) begin
            tick();
            cycles++;
        end
        bus_if.start = 1'b0;
        check("b2b spacing", cycles, W + 1);
        check("b2b second sum", bus_if.sum, 8'h80);
        check("b2b second cout", bus_if.cout, 0);
        tick();
        check("b2b idle busy", bus_if.busy, 0);

        // reset in the middle of RUN
        bus_if.start = 1'b1;
        bus_if.a     = 8'h33;
        bus_if.b     = 8'h44;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid-run busy before reset", bus_if.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus_if.busy, 0);
        check("abort done", bus_if.done, 0);
        check("abort sum", bus_if.sum, 0);
        check("abort cout", bus_if.cout, 0);
        tick();
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.done || bus_if.busy) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 0);
        check("abort state idle", state, IDLE);
        run_add("after abort 0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that feeds a one-bit full-adder cell one bit per clock, LSB first.
- The carry-out is held in a flip-flop and fed back into the cell on the next cycle.
- Sits directly upstream of the full-adder cell. It sequences operands into the cell and collects the sum/carry it produces.
- Trades latency (WIDTH cycles) for area, for the lab datapath. Controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on the accepted start edge
- b  input  WIDTH  operand B, captured on the accepted start edge
- cin  input  1  initial carry, captured on the accepted start edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held until next completion

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - shift registers, carry flop and bit counter all cleared
- States:
  - IDLE: wait for start.
  - RUN: shift one bit per cycle.
  - DONE: one cycle; done=1.
- IDLE->RUN, when start=1 at edge E0:
  - a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, busy<=1.
- RUN, each edge:
  - cell inputs = a_sr[0], b_sr[0], carry.
  - s_sr <= {s, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1 (zero fill).
  - carry <= cell carry-out; cnt <= cnt+1.
- RUN->DONE, on the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - sum <= {s, s_sr[WIDTH-1:1]}, cout <= cell carry-out.
  - done <= 1, busy <= 0.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. exactly WIDTH clocks after the start-sampling edge.
- DONE->IDLE on the next edge, done<=0. If start=1 in the DONE cycle it is accepted: DONE->RUN with a new operand capture, done<=0, busy<=1. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands a/b/cin may change freely after capture without effect.
- sum/cout keep the last result through IDLE, RUN and DONE. They change only at a completion edge or at reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- cnt width is $clog2(WIDTH). The count never wraps because RUN exits at WIDTH-1.
- Reset asserted mid-RUN aborts immediately: all outputs go to reset values and no done pulse is issued. After release, the block is in IDLE.
- No combinational path from any input to any output. All outputs are flop outputs.

Decomposition:
- Shared package (serial_pkg):
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH constant
- One natural sub-module, fa_bit: the one-bit full-adder cell.
  - Ports a, b, cin, sum, cout.
  - sum = a^b^cin; cout = majority(a,b,cin).
  - Instantiated once inside serial_adder.
- Everything else (FSM, shift registers, counter, output registers) lives in serial_adder.

Test Plan:
- Reset check: rst_n=0 with random inputs -> busy=0, done=0, sum=0x00, cout=0. Release rst_n -> no activity until start.
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 8 clocks after the start edge, sum=0x96, cout=0, busy high for exactly 8 cycles.
- Carry ripple:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Handshake and hold:
  - Start at 0x10+0x20, then pulse start with 0x01+0x01 at cycle 3 -> second start ignored; result sum=0x30.
  - Change a/b mid-RUN -> no effect.
  - sum stays 0x30 for 20 idle cycles.
- Back-to-back: start held high continuously, operands 0x01+0x02 then 0x7F+0x01 -> done pulses 9 cycles apart, sums 0x03 then 0x80, cout 0 both times.
- Reset mid-operation: rst_n low at cycle 4 of RUN -> outputs to reset values immediately, no done pulse. New start with 0x0F+0x01 afterwards -> sum=0x10.
